// File: rtl/scancode_digit_sequencer.sv
// PS/2 scancode front end: tracks make/break/extended prefixes, pushes digit make codes into a FIFO.
// Optional auto-repeat suppression via `define SCANSEQ_TYPEMATIC_FILTER_EN.
module scancode_digit_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          code_valid,
  input  logic [7:0]                    code,
  output logic                          dout_valid,
  output logic [3:0]                    dout,
  input  logic                          dout_ready,
  output logic                          err_bad_code,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

  state_t         state_q;
  logic           err_q;
  logic           overflow_q;
  logic [3:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]  count_q, count_d;

  logic           is_digit;
  logic [3:0]     digit;
  logic           repeat_hit;
  logic           push_req, bad_code, full, pop, push_ok;

  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    case (code)
      8'h45: digit = 4'd0;
      8'h16: digit = 4'd1;
      8'h1E: digit = 4'd2;
      8'h26: digit = 4'd3;
      8'h25: digit = 4'd4;
      8'h2E: digit = 4'd5;
      8'h36: digit = 4'd6;
      8'h3D: digit = 4'd7;
      8'h3E: digit = 4'd8;
      8'h46: digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

`ifdef SCANSEQ_TYPEMATIC_FILTER_EN
  logic       hold_vld_q;
  logic [7:0] hold_code_q;

  assign repeat_hit = hold_vld_q && (code == hold_code_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_vld_q  <= 1'b0;
      hold_code_q <= 8'h00;
    end else if (code_valid) begin
      // Hold tracks the last accepted digit even if the FIFO drops it.
      if (state_q == IDLE && is_digit && !repeat_hit) begin
        hold_vld_q  <= 1'b1;
        hold_code_q <= code;
      end else if (state_q == BREAK && repeat_hit) begin
        hold_vld_q  <= 1'b0;
      end
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  always_comb begin
    push_req = 1'b0;
    bad_code = 1'b0;
    if (code_valid && state_q == IDLE && code != 8'hF0 && code != 8'hE0) begin
      if (is_digit) push_req = !repeat_hit;
      else          bad_code = 1'b1;
    end
  end

  assign full    = (count_q == LW'(FIFO_DEPTH));
  assign pop     = dout_valid && dout_ready;
  assign push_ok = push_req && (!full || pop);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      err_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      err_q <= bad_code;
      if (push_req && full && !pop) overflow_q <= 1'b1;
      if (code_valid) begin
        case (state_q)
          IDLE: begin
            if (code == 8'hF0)      state_q <= BREAK;
            else if (code == 8'hE0) state_q <= EXT;
            else                    state_q <= IDLE;
          end
          EXT:       state_q <= (code == 8'hF0) ? EXT_BREAK : IDLE;
          default:   state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 4'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= digit;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign dout_valid   = (count_q != '0);
  assign dout         = mem_q[rd_ptr_q];
  assign err_bad_code = err_q;
  assign overflow     = overflow_q;
  assign level        = count_q;

endmodule

// File: tb/tb_scancode_digit_sequencer.sv
// Directed bench for scancode_digit_sequencer (FIFO_DEPTH=4); honours SCANSEQ_TYPEMATIC_FILTER_EN if defined.
module tb_scancode_digit_sequencer;

  logic       clk;
  logic       resetn;
  logic       code_valid;
  logic [7:0] code;
  logic       dout_valid;
  logic [3:0] dout;
  logic       dout_ready;
  logic       err_bad_code;
  logic       overflow;
  logic [2:0] level;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] dmap [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                            8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  scancode_digit_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .code_valid   (code_valid),
    .code         (code),
    .dout_valid   (dout_valid),
    .dout         (dout),
    .dout_ready   (dout_ready),
    .err_bad_code (err_bad_code),
    .overflow     (overflow),
    .level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    code_valid = 1'b1;
    code       = b;
    tick();
    code_valid = 1'b0;
  endtask

  function automatic bit is_digit_code(input logic [7:0] b);
    for (int i = 0; i < 10; i++) if (dmap[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic [7:0] rb;
    int         exp_ones;
    logic [3:0] exp_drain [4] = '{4'd2, 4'd3, 4'd4, 4'd6};

    resetn     = 1'b1;
    code_valid = 1'b0;
    code       = 8'h00;
    dout_ready = 1'b0;
    #1 resetn = 1'b0;
    #2;
    check("rst_level", level, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_err", err_bad_code, 0);
    check("rst_ovf", overflow, 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Digit map: each byte visible one cycle after, popped on the next edge.
    dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      code_valid = 1'b1;
      code       = dmap[i];
      tick();
      check("map_valid", dout_valid, 1);
      check("map_dout", dout, i);
      check("map_level", level, 1);
      check("map_err", err_bad_code, 0);
    end
    code_valid = 1'b0;
    tick();
    check("map_drained", level, 0);

    // Prefix sequences must not push.
    send(8'hF0); send(8'h16);
    check("brk_level", level, 0);
    check("brk_err", err_bad_code, 0);
    send(8'hE0); send(8'h16);
    check("ext_level", level, 0);
    check("ext_err", err_bad_code, 0);
    send(8'hE0); send(8'hF0); send(8'h16);
    check("extbrk_level", level, 0);
    send(8'h1E);
    check("post_pfx_valid", dout_valid, 1);
    check("post_pfx_dout", dout, 2);
    tick();
    check("post_pfx_pop", level, 0);

    // Bad codes.
    send(8'h03);
    check("bad_err", err_bad_code, 1);
    check("bad_level", level, 0);
    tick();
    check("bad_err_pulse", err_bad_code, 0);
    for (int k = 0; k < 5; k++) begin
      do rb = 8'($urandom_range(0, 255));
      while (is_digit_code(rb) || rb == 8'hF0 || rb == 8'hE0);
      send(rb);
      check("rnd_bad_err", err_bad_code, 1);
      tick();
      check("rnd_bad_clear", err_bad_code, 0);
    end
    check("rnd_bad_level", level, 0);

    // Overflow under backpressure: 1,2,3,4 queued, 5 dropped.
    dout_ready = 1'b0;
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    check("ovf_full_level", level, 4);
    check("ovf_not_yet", overflow, 0);
    send(8'h2E);
    check("ovf_level", level, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_head", dout, 1);
    // Full FIFO, push 6 with simultaneous pop of 1.
    dout_ready = 1'b1;
    code_valid = 1'b1;
    code       = 8'h36;
    tick();
    code_valid = 1'b0;
    check("fullpp_level", level, 4);
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", dout_valid, 1);
      check("drain_dout", dout, exp_drain[k]);
      tick();
    end
    check("drain_level", level, 0);
    check("ovf_sticky", overflow, 1);

    // Typematic sequence.
    dout_ready = 1'b0;
    send(8'h16); send(8'h16); send(8'h16); send(8'hF0); send(8'h16); send(8'h16);
`ifdef SCANSEQ_TYPEMATIC_FILTER_EN
    exp_ones = 2;
`else
    exp_ones = 4;
`endif
    check("typ_level", level, exp_ones);
    dout_ready = 1'b1;
    for (int k = 0; k < exp_ones; k++) begin
      check("typ_dout", dout, 1);
      tick();
    end
    check("typ_drained", level, 0);

    // Reset mid-sequence with 3 queued and FSM in EXT_BREAK.
    dout_ready = 1'b0;
    send(8'h45); send(8'h16); send(8'h1E);
    send(8'hE0); send(8'hF0);
    check("pre_rst_level", level, 3);
    resetn = 1'b0;
    #2;
    check("mid_rst_level", level, 0);
    check("mid_rst_valid", dout_valid, 0);
    check("mid_rst_dout", dout, 0);
    check("mid_rst_err", err_bad_code, 0);
    check("mid_rst_ovf", overflow, 0);
    tick();
    resetn = 1'b1;
    tick();
    send(8'h46);
    check("post_rst_valid", dout_valid, 1);
    check("post_rst_dout", dout, 9);
    check("post_rst_level", level, 1);
    check("post_rst_err", err_bad_code, 0);
    tick();
    check("post_rst_hold", level, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scancode_digit_sequencer.md
# scancode_digit_sequencer

Front-end controller for the PS/2 keypad path. It consumes a byte-wide scancode stream and tracks make, break (0xF0) and extended (0xE0) prefixes with a small state machine. Make codes for digit keys are translated to 4-bit values and buffered in a FIFO, which drains to the downstream consumer over a valid/ready handshake. It sits between the PS/2 byte receiver and the digit-entry logic, and replaces direct use of the combinational scancode decoder.

## Interface
- FIFO_DEPTH, 4, number of digit entries buffered; power of two, ≥2
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- code_valid  input  1  `code` holds a new byte this cycle; always accepted
- code  input  8  scancode byte
- dout_valid  output  1  FIFO head is valid
- dout  output  4  digit at FIFO head (0–9)
- dout_ready  input  1  consumer takes the head this cycle when `dout_valid`=1
- err_bad_code  output  1  one-cycle pulse: unrecognised make code
- overflow  output  1  sticky: a digit was dropped because the FIFO was full
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Digit map (make codes):
  - 0x45→0, 0x16→1, 0x1E→2, 0x26→3, 0x25→4
  - 0x2E→5, 0x36→6, 0x3D→7, 0x3E→8, 0x46→9
- State machine: the state advances only on cycles with `code_valid`=1.
  - IDLE:
    - 0xF0 → BREAK
    - 0xE0 → EXT
    - digit code → push digit, stay in IDLE
    - any other byte → pulse `err_bad_code`, stay in IDLE
  - BREAK: any byte → IDLE; the byte is consumed with no push and no error. A second 0xF0 is also consumed.
  - EXT:
    - 0xF0 → EXT_BREAK
    - any other byte → IDLE, discarded with no push and no error
  - EXT_BREAK: any byte → IDLE, discarded.
- FIFO:
  - Push occurs on a digit make code (subject to Configuration).
  - Pop occurs when `dout_valid` and `dout_ready` are both 1.
  - Push when full: the digit is dropped and `overflow` is set. Exception: a pop in the same cycle frees the slot, so the push is accepted and `level` is unchanged.
  - Push and pop in the same cycle with the FIFO non-full: `level` is unchanged and order is preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- `overflow` clears only on reset.
- `dout` holds its value while `dout_valid`=0. Its content in that case is don't-care for verification.

## Timing
- Reset (asynchronous assert, synchronous-safe release) forces:
  - state=IDLE, FIFO empty, `level`=0
  - `dout_valid`=0, `dout`=0, `err_bad_code`=0, `overflow`=0
  - typematic hold register cleared
- Reset asserted mid-sequence (for example in EXT_BREAK or with the FIFO full) discards all pending state. The first byte after release is interpreted from IDLE.
- Latency:
  - A digit byte accepted at edge N into an empty FIFO gives `dout_valid`=1 and the correct `dout` after edge N.
  - With `dout_ready` held at 1, that digit is popped at edge N+1.
- `err_bad_code` is high for exactly the one cycle following the offending edge.
- `level` is registered and updated at the same edge as the push or pop.
- Throughput: one byte per cycle in and one digit per cycle out, sustained.

## Configuration
- Macro `SCANSEQ_TYPEMATIC_FILTER_EN`.
- Defined: a hold register (valid + 8-bit code) suppresses auto-repeat.
  - A digit make code equal to the held code while the hold is valid is dropped: no push, no error.
  - An accepted digit push loads the hold register.
  - The byte consumed in BREAK clears the hold if it equals the held code.
  - A different digit make code is pushed and replaces the hold.
  - The hold is updated even when the push is dropped for overflow.
- Undefined: no hold register; every digit make code is pushed.

## Test plan
- Digit map:
  - Stimulus: 0x45, 0x16, 0x1E, 0x26, 0x25, 0x2E, 0x36, 0x3D, 0x3E, 0x46, with `dout_ready`=1 throughout.
  - Required: `dout` sequence 0..9, each valid one cycle after its byte, `err_bad_code` never high.
- Prefixes:
  - Stimulus: 0xF0 0x16 → required: no push.
  - Stimulus: 0xE0 0x16 → required: no push.
  - Stimulus: 0xE0 0xF0 0x16 → required: no push.
  - Stimulus: a following 0x1E → required: digit 2 output. State ends in IDLE after each sequence.
- Bad code: byte 0x03 in IDLE → `err_bad_code` pulses for one cycle, `level` stays 0. Random non-digit bytes in IDLE → one pulse each.
- Overflow / backpressure:
  - With `dout_ready`=0, push 5 digits (FIFO_DEPTH=4) → `level`=4, `overflow`=1, fifth digit lost.
  - Release `dout_ready` → first four digits emerge in order.
  - With the FIFO full, push plus pop in the same cycle → accepted, `level` stays 4.
- Typematic, with the macro defined:
  - Stimulus: 0x16 0x16 0x16 0xF0 0x16 0x16 → required: digit 1 output exactly twice.
  - Same stimulus with the macro undefined → required: digit 1 output four times.
- Reset mid-operation:
  - Stimulus: drive 0xE0 0xF0, assert `resetn`=0 with 3 entries queued, release, then send 0x46.
  - Required: all outputs at reset values while reset is asserted, then a single digit 9 and `level`=1.
